// File: rtl/fire2_expand_feeder.sv
// fire2_expand_feeder: buffers 16-channel squeeze vectors and re-serialises them
// into one channel word per cycle for the fire2 expand MAC arrays.
// Ports: clk/rst (async active-low), start (layer clear), in_valid/in_vec/in_last
// (vector input), out_valid/out_ready/out_data/out_ch/out_last (word stream),
// done (layer drained), overflow (sticky drop flag), count (stored vectors).
// Latency: a vector written at edge t is presented (ch=0) from t+1.
// Backpressure: out_ready=0 freezes the stream; a full buffer drops input vectors.
module fire2_expand_feeder #(
  parameter int WIDTH = 16,
  parameter int CH    = 16,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       in_valid,
  input  logic [WIDTH-1:0]           in_vec [0:CH-1],
  input  logic                       in_last,
  input  logic                       out_ready,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(CH)-1:0]      out_ch,
  output logic                       out_last,
  output logic                       done,
  output logic                       overflow,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = PW + 1;
  localparam int CHW = $clog2(CH);
  localparam logic [CW-1:0]  DEPTH_C = CW'(DEPTH);
  localparam logic [CHW-1:0] CH_LAST = CHW'(CH - 1);
  localparam logic [CW-1:0]  ONE_C   = CW'(1);

  logic [WIDTH-1:0] mem [0:DEPTH-1][0:CH-1];
  logic [PW-1:0]    wp;
  logic [PW-1:0]    rp;
  logic [CHW-1:0]   ch;
  logic [CW-1:0]    cnt;
  logic             last_seen;
  logic             done_q;
  logic             ovf_q;

  logic xfer;
  logic pop;
  logic in_ok;
  logic push;
  logic drop;

  assign xfer  = out_valid && out_ready;
  assign pop   = xfer && (ch == CH_LAST);
  // Input is ignored during a start pulse and once the layer has drained.
  assign in_ok = in_valid && !start && !done_q;
  // A full buffer still accepts when the head vector leaves in the same cycle.
  assign push  = in_ok && ((cnt != DEPTH_C) || pop);
  assign drop  = in_ok && !((cnt != DEPTH_C) || pop);

  assign out_valid = (cnt != '0);
  assign out_data  = mem[rp][ch];
  assign out_ch    = ch;
  // A same-cycle in_valid means more data may follow, so this is not yet the end.
  assign out_last  = out_valid && (ch == CH_LAST) && (cnt == ONE_C) && last_seen && !in_valid;
  assign done      = done_q;
  assign overflow  = ovf_q;
  assign count     = cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int d = 0; d < DEPTH; d++) begin
        for (int c = 0; c < CH; c++) begin
          mem[d][c] <= '0;
        end
      end
    end else if (push) begin
      for (int c = 0; c < CH; c++) begin
        mem[wp][c] <= in_vec[c];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp        <= '0;
      rp        <= '0;
      ch        <= '0;
      cnt       <= '0;
      last_seen <= 1'b0;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else if (start) begin
      wp        <= '0;
      rp        <= '0;
      ch        <= '0;
      cnt       <= '0;
      last_seen <= 1'b0;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      if (push) begin
        wp <= wp + 1'b1;
      end
      if (xfer) begin
        if (ch == CH_LAST) begin
          ch <= '0;
          rp <= rp + 1'b1;
        end else begin
          ch <= ch + 1'b1;
        end
      end
      if (push && !pop) begin
        cnt <= cnt + ONE_C;
      end else if (pop && !push) begin
        cnt <= cnt - ONE_C;
      end
      if (in_last) begin
        last_seen <= 1'b1;
      end
      if (xfer && out_last) begin
        done_q <= 1'b1;
      end
      if (drop) begin
        ovf_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fire2_expand_feeder.sv
// Directed bench for fire2_expand_feeder: single vector, backpressure,
// fill/overflow, full-with-pop, wrap with end-of-layer, async reset and start.
module tb_fire2_expand_feeder;

  logic        clk;
  logic        rst;
  logic        start;
  logic        in_valid;
  logic [15:0] in_vec [0:15];
  logic        in_last;
  logic        out_ready;
  logic        out_valid;
  logic [15:0] out_data;
  logic [3:0]  out_ch;
  logic        out_last;
  logic        done;
  logic        overflow;
  logic [2:0]  count;

  int n_chk = 0;
  int n_bad = 0;

  fire2_expand_feeder #(.WIDTH(16), .CH(16), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_vec(in_vec),
    .in_last(in_last), .out_ready(out_ready), .out_valid(out_valid),
    .out_data(out_data), .out_ch(out_ch), .out_last(out_last), .done(done),
    .overflow(overflow), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word c of test vector v.
  function automatic logic [31:0] vd(input int v, input int c);
    return 32'(v * 256 + c + 1);
  endfunction

  task automatic set_vec(input int v);
    for (int c = 0; c < 16; c++) in_vec[c] = 16'(vd(v, c));
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_one(input int v);
    set_vec(v);
    in_valid = 1'b1;
    step;
    in_valid = 1'b0;
  endtask

  task automatic start_pulse;
    start = 1'b1;
    step;
    start = 1'b0;
  endtask

  initial begin
    int k;
    int pushed;
    logic ev;

    rst = 1'b0; start = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    set_vec(0);
    #1;
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_data", 32'(out_data), 0);
    chk("rst_ch", 32'(out_ch), 0);
    chk("rst_last", 32'(out_last), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_count", 32'(count), 0);
    #13 rst = 1'b1;
    step;

    // Single vector, words 1..16 on consecutive cycles.
    out_ready = 1'b1;
    push_one(0);
    for (int i = 0; i < 16; i++) begin
      chk("t1_valid", 32'(out_valid), 1);
      chk("t1_data", 32'(out_data), 32'(i + 1));
      chk("t1_ch", 32'(out_ch), 32'(i));
      chk("t1_last", 32'(out_last), 0);
      step;
    end
    chk("t1_empty", 32'(out_valid), 0);
    chk("t1_count", 32'(count), 0);

    // Backpressure pattern 1,0,0,1 repeating.
    out_ready = 1'b0;
    push_one(1);
    k = 0;
    for (int c = 0; c < 64 && k < 16; c++) begin
      out_ready = ((c % 4) == 0) || ((c % 4) == 3);
      chk("t2_valid", 32'(out_valid), 1);
      chk("t2_data", 32'(out_data), vd(1, k));
      chk("t2_ch", 32'(out_ch), 32'(k));
      step;
      if (out_ready) k++;
    end
    chk("t2_xfers", 32'(k), 16);
    chk("t2_empty", 32'(out_valid), 0);

    // Fill to DEPTH, fifth vector dropped.
    out_ready = 1'b0;
    for (int v = 0; v < 5; v++) begin
      set_vec(2 + v);
      in_valid = 1'b1;
      step;
      if (v == 3) begin
        chk("t3_ovf_pre", 32'(overflow), 0);
        chk("t3_cnt_pre", 32'(count), 4);
      end
    end
    in_valid = 1'b0;
    chk("t3_count", 32'(count), 4);
    chk("t3_ovf", 32'(overflow), 1);
    out_ready = 1'b1;
    for (int i = 0; i < 64; i++) begin
      chk("t3_valid", 32'(out_valid), 1);
      chk("t3_data", 32'(out_data), vd(2 + i / 16, i % 16));
      chk("t3_ch", 32'(out_ch), 32'(i % 16));
      step;
    end
    chk("t3_empty", 32'(out_valid), 0);
    chk("t3_ovf_sticky", 32'(overflow), 1);
    start_pulse;
    chk("t3_ovf_clr", 32'(overflow), 0);

    // Full buffer, push coincides with head's final word.
    out_ready = 1'b0;
    for (int v = 10; v < 14; v++) push_one(v);
    chk("t4_full", 32'(count), 4);
    out_ready = 1'b1;
    repeat (15) step;
    chk("t4_ch15", 32'(out_ch), 15);
    chk("t4_d15", 32'(out_data), vd(10, 15));
    push_one(14);
    chk("t4_count", 32'(count), 4);
    chk("t4_ovf", 32'(overflow), 0);
    chk("t4_ch0", 32'(out_ch), 0);
    for (int i = 0; i < 64; i++) begin
      chk("t4_data", 32'(out_data), vd(11 + i / 16, i % 16));
      chk("t4_valid", 32'(out_valid), 1);
      step;
    end
    chk("t4_empty", 32'(out_valid), 0);

    // Ten vectors through the ring with gappy out_ready, then end of layer.
    start_pulse;
    k = 0;
    pushed = 0;
    for (int cyc = 0; cyc < 1000 && k < 160; cyc++) begin
      in_valid  = ((cyc % 20) == 0) && (pushed < 10);
      if (in_valid) set_vec(20 + pushed);
      in_last   = (pushed == 10);
      out_ready = ((cyc % 8) != 3);
      ev = (k < 16 * pushed);
      chk("t5_valid", 32'(out_valid), 32'(ev));
      if (ev) begin
        chk("t5_data", 32'(out_data), vd(20 + k / 16, k % 16));
        chk("t5_ch", 32'(out_ch), 32'(k % 16));
        chk("t5_last", 32'(out_last), 32'(k == 159));
      end
      chk("t5_done_lo", 32'(done), 0);
      step;
      if (in_valid) pushed++;
      if (ev && out_ready) k++;
    end
    in_valid = 1'b0;
    chk("t5_words", 32'(k), 160);
    chk("t5_done", 32'(done), 1);
    chk("t5_empty", 32'(out_valid), 0);
    chk("t5_ovf", 32'(overflow), 0);
    push_one(30);
    chk("t5_ign_count", 32'(count), 0);
    chk("t5_ign_valid", 32'(out_valid), 0);
    chk("t5_ign_ovf", 32'(overflow), 0);
    chk("t5_done_hold", 32'(done), 1);

    // Async reset mid-vector, then start with a colliding in_valid.
    in_last = 1'b0;
    start_pulse;
    chk("t6_done_clr", 32'(done), 0);
    out_ready = 1'b1;
    push_one(40);
    repeat (5) step;
    chk("t6_mid_ch", 32'(out_ch), 5);
    chk("t6_mid_data", 32'(out_data), vd(40, 5));
    #2 rst = 1'b0;
    #1;
    chk("t6_ar_valid", 32'(out_valid), 0);
    chk("t6_ar_data", 32'(out_data), 0);
    chk("t6_ar_ch", 32'(out_ch), 0);
    chk("t6_ar_count", 32'(count), 0);
    chk("t6_ar_last", 32'(out_last), 0);
    #2 rst = 1'b1;
    step;
    set_vec(41);
    start = 1'b1;
    in_valid = 1'b1;
    step;
    start = 1'b0;
    in_valid = 1'b0;
    chk("t6_st_count", 32'(count), 0);
    chk("t6_st_valid", 32'(out_valid), 0);
    chk("t6_st_ovf", 32'(overflow), 0);
    step;
    chk("t6_st_count2", 32'(count), 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
